// File: rtl/i2c_ram_arbiter_if.sv
// Requester-side bus of the I2C slave register RAM arbiter.
// One instance per requester: command (req/we/addr/wdata) in one direction,
// grant and read return (gnt/rvalid/rdata) in the other.
interface i2c_ram_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  // Requester side: issues commands, receives grant and read data.
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  // Arbiter side: accepts commands, returns grant and read data.
  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/i2c_ram_arbiter.sv
// Two-requester arbiter/sequencer for the single-port 32x8 register RAM of
// the I2C slave. Requester A is the I2C byte engine, requester B the host /
// debug port. Accesses are serialised; reads return data two cycles after
// the grant with a one-cycle rvalid pulse to the owning requester.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate ownership on ties
// (the requester that was not last_owner wins). Without it, A always wins
// ties and last_owner is tracked but does not affect arbitration.
module i2c_ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  i2c_ram_arbiter_if.slave        bus_a,
  i2c_ram_arbiter_if.slave        bus_b,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_din,
  output logic                    ram_we,
  input  logic [DATA_W-1:0]       ram_dout,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    RDRET  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  state_t            state, state_d;
  owner_t            owner, owner_d;
  owner_t            last_owner, last_owner_d;
  owner_t            pick;
  logic              is_read, is_read_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_din_d;
  logic              ram_we_d;
  logic              gnt_a, gnt_a_d, gnt_b, gnt_b_d;
  logic              rvalid_a, rvalid_a_d, rvalid_b, rvalid_b_d;
  logic [DATA_W-1:0] rdata_a, rdata_a_d, rdata_b, rdata_b_d;

  // Arbitration: a lone requester wins outright; a tie is resolved by policy.
  always_comb begin
    pick = OWN_A;
    if (bus_a.req && bus_b.req) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick = (last_owner == OWN_A) ? OWN_B : OWN_A;
`else
      pick = OWN_A;
`endif
    end else if (bus_b.req) begin
      pick = OWN_B;
    end
  end

  // Next-state and next-output logic for the access sequencer.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_owner_d = last_owner;
    is_read_d    = is_read;
    ram_addr_d   = ram_addr;
    ram_din_d    = ram_din;
    ram_we_d     = 1'b0;
    gnt_a_d      = 1'b0;
    gnt_b_d      = 1'b0;
    rvalid_a_d   = 1'b0;
    rvalid_b_d   = 1'b0;
    rdata_a_d    = rdata_a;
    rdata_b_d    = rdata_b;

    unique case (state)
      IDLE: begin
        if (bus_a.req || bus_b.req) begin
          owner_d      = pick;
          last_owner_d = pick;
          state_d      = ACCESS;
          if (pick == OWN_A) begin
            ram_addr_d = bus_a.addr;
            ram_din_d  = bus_a.wdata;
            ram_we_d   = bus_a.we;
            is_read_d  = !bus_a.we;
            gnt_a_d    = 1'b1;
          end else begin
            ram_addr_d = bus_b.addr;
            ram_din_d  = bus_b.wdata;
            ram_we_d   = bus_b.we;
            is_read_d  = !bus_b.we;
            gnt_b_d    = 1'b1;
          end
        end
      end
      ACCESS: begin
        // The RAM samples the address at the end of this cycle.
        state_d = is_read ? RDWAIT : IDLE;
      end
      RDWAIT: begin
        // ram_dout now reflects the address presented during ACCESS.
        state_d = RDRET;
        if (owner == OWN_A) begin
          rdata_a_d  = ram_dout;
          rvalid_a_d = 1'b1;
        end else begin
          rdata_b_d  = ram_dout;
          rvalid_b_d = 1'b1;
        end
      end
      RDRET: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_A;
      last_owner <= OWN_B;
      is_read    <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_we     <= 1'b0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      rvalid_a   <= 1'b0;
      rvalid_b   <= 1'b0;
      rdata_a    <= '0;
      rdata_b    <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= last_owner_d;
      is_read    <= is_read_d;
      ram_addr   <= ram_addr_d;
      ram_din    <= ram_din_d;
      ram_we     <= ram_we_d;
      gnt_a      <= gnt_a_d;
      gnt_b      <= gnt_b_d;
      rvalid_a   <= rvalid_a_d;
      rvalid_b   <= rvalid_b_d;
      rdata_a    <= rdata_a_d;
      rdata_b    <= rdata_b_d;
    end
  end

  assign busy         = (state != IDLE);
  assign bus_a.gnt    = gnt_a;
  assign bus_a.rvalid = rvalid_a;
  assign bus_a.rdata  = rdata_a;
  assign bus_b.gnt    = gnt_b;
  assign bus_b.rvalid = rvalid_b;
  assign bus_b.rdata  = rdata_b;

endmodule

// File: tb/tb_i2c_ram_arbiter.sv
// Self-checking bench for i2c_ram_arbiter. A transaction-level model
// predicts every output from the grant it decides on: grant edge, owner,
// command and the read data taken from a shadow copy of the RAM. Directed
// scenarios pin the model with literal values; a randomized phase then
// exercises contention, back-to-back commands and stray resets.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
`timescale 1ns/1ps
module tb_i2c_ram_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2c_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  i2c_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_we;
  logic              busy;

  i2c_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus_a    (bus_a),
    .bus_b    (bus_b),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .busy     (busy)
  );

  // Synchronous single-port RAM attached to the arbiter.
  logic [DATA_W-1:0] ram [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;
  bit rst_s  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- requesters ----------------
  cmd_t q_a[$];
  cmd_t q_b[$];
  bit   hold[2] = '{1'b0, 1'b0};
  cmd_t cur[2]  = '{'0, '0};

  function automatic cmd_t mk(input bit we, input int addr, input int data);
    cmd_t c;
    c.we   = we;
    c.addr = ADDR_W'(addr);
    c.data = DATA_W'(data);
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    return mk(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
              int'($urandom_range(0, 255)));
  endfunction

  // Each requester holds its command until it sees its grant, then presents
  // the next queued command (or drops req) in the following cycle.
  task automatic drive();
    bit g0, g1;
    g0 = (bus_a.gnt === 1'b1);
    g1 = (bus_b.gnt === 1'b1);
    if (hold[0] && g0) hold[0] = 1'b0;
    if (hold[1] && g1) hold[1] = 1'b0;
    if (!hold[0] && q_a.size() > 0) begin cur[0] = q_a.pop_front(); hold[0] = 1'b1; end
    if (!hold[1] && q_b.size() > 0) begin cur[1] = q_b.pop_front(); hold[1] = 1'b1; end
    bus_a.req   = hold[0];
    bus_a.we    = cur[0].we;
    bus_a.addr  = cur[0].addr;
    bus_a.wdata = cur[0].data;
    bus_b.req   = hold[1];
    bus_b.we    = cur[1].we;
    bus_b.addr  = cur[1].addr;
    bus_b.wdata = cur[1].data;
  endtask

  // ---------------- transaction-level model ----------------
  logic [DATA_W-1:0] mmem [DEPTH] = '{default: '0};
  int                free_edge = 0;   // first edge at which a grant may occur
  bit                m_last    = 1'b1; // 0 = A, 1 = B
  bit                t_valid   = 1'b0;
  int                t_edge    = 0;
  bit                t_owner   = 1'b0;
  bit                t_we      = 1'b0;
  logic [ADDR_W-1:0] t_addr    = '0;
  logic [DATA_W-1:0] t_din     = '0;
  bit                pend[2]     = '{1'b0, 1'b0};
  int                pend_edge[2] = '{0, 0};
  logic [DATA_W-1:0] pend_val[2] = '{'0, '0};
  logic [DATA_W-1:0] cur_rd[2]   = '{'0, '0};

  bit                exp_gnt[2] = '{1'b0, 1'b0};
  bit                exp_rv[2]  = '{1'b0, 1'b0};
  bit                exp_we     = 1'b0;
  bit                exp_busy   = 1'b0;
  logic [ADDR_W-1:0] exp_addr   = '0;
  logic [DATA_W-1:0] exp_din    = '0;

  // Decide whether the upcoming edge grants, and to whom.
  task automatic plan();
    int g;
    bit own;
    cmd_t c;
    g = cyc + 1;
    if (rst_s || g < free_edge || !(hold[0] || hold[1])) return;
    if (hold[0] && hold[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
      own = ~m_last;
`else
      own = 1'b0;
`endif
    end else begin
      own = hold[1];
    end
    c       = cur[own];
    t_valid = 1'b1;
    t_edge  = g;
    t_owner = own;
    t_we    = c.we;
    t_addr  = c.addr;
    t_din   = c.data;
    m_last  = own;
    if (c.we) begin
      mmem[c.addr] = c.data;
      free_edge    = g + 2;
    end else begin
      pend[own]      = 1'b1;
      pend_edge[own] = g + 2;
      pend_val[own]  = mmem[c.addr];
      free_edge      = g + 4;
    end
  endtask

  // Apply the edge just taken and derive the expected outputs after it.
  task automatic model_edge();
    int d;
    if (rst_s) begin
      t_valid   = 1'b0;
      pend      = '{1'b0, 1'b0};
      cur_rd    = '{'0, '0};
      m_last    = 1'b1;
      free_edge = cyc + 1;
      chk_en    = 1'b1;
    end else begin
      for (int x = 0; x < 2; x++)
        if (pend[x] && pend_edge[x] == cyc) begin
          cur_rd[x] = pend_val[x];
          pend[x]   = 1'b0;
        end
    end
    exp_gnt  = '{1'b0, 1'b0};
    exp_rv   = '{1'b0, 1'b0};
    exp_we   = 1'b0;
    exp_busy = 1'b0;
    exp_addr = '0;
    exp_din  = '0;
    if (t_valid) begin
      d        = cyc - t_edge;
      exp_addr = t_addr;
      exp_din  = t_din;
      exp_busy = (d < (t_we ? 1 : 3));
      if (d == 0) begin
        exp_gnt[t_owner] = 1'b1;
        exp_we           = t_we;
      end
      if (!t_we && d == 2) exp_rv[t_owner] = 1'b1;
    end
  endtask

  // One clock cycle: present commands, let the model decide, take the edge.
  task automatic step();
    drive();
    rst_s = reset;
    plan();
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
  endtask

  // Compare every DUT output against the model once per cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt_a",    32'(bus_a.gnt),    32'(exp_gnt[0]));
      check("gnt_b",    32'(bus_b.gnt),    32'(exp_gnt[1]));
      check("rvalid_a", 32'(bus_a.rvalid), 32'(exp_rv[0]));
      check("rvalid_b", 32'(bus_b.rvalid), 32'(exp_rv[1]));
      check("rdata_a",  32'(bus_a.rdata),  32'(cur_rd[0]));
      check("rdata_b",  32'(bus_b.rdata),  32'(cur_rd[1]));
      check("ram_we",   32'(ram_we),       32'(exp_we));
      check("ram_addr", 32'(ram_addr),     32'(exp_addr));
      check("ram_din",  32'(ram_din),      32'(exp_din));
      check("busy",     32'(busy),         32'(exp_busy));
    end
  end

  task automatic wait_gnt(input bit x, input int limit, input string name);
    int n;
    logic g;
    n = 0;
    do begin
      step();
      n++;
      g = x ? bus_b.gnt : bus_a.gnt;
    end while (g !== 1'b1 && n < limit);
    check(name, 32'(g), 32'(1));
  endtask

  task automatic drain(input int limit, input string name);
    int n;
    n = 0;
    while ((q_a.size() > 0 || q_b.size() > 0 || hold[0] || hold[1] || busy !== 1'b0) && n < limit) begin
      step();
      n++;
    end
    check(name, 32'(n < limit), 32'(1));
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int n_g;
    int gord[4];
    int n_rv;
    logic [DATA_W-1:0] rv[2];
    bit seen;
    int g1, g2, n_we;

    reset = 1'b1;
    repeat (3) step();
    check("rst_busy",     32'(busy),         32'(0));
    check("rst_gnt_a",    32'(bus_a.gnt),    32'(0));
    check("rst_ram_we",   32'(ram_we),       32'(0));
    check("rst_ram_addr", 32'(ram_addr),     32'(0));
    check("rst_rvalid_b", 32'(bus_b.rvalid), 32'(0));
    check("rst_rdata_a",  32'(bus_a.rdata),  32'(0));
    reset = 1'b0;

    // A writes 0xA5 to address 5.
    q_a.push_back(mk(1'b1, 5, 8'hA5));
    step();
    check("wr_gnt_a",    32'(bus_a.gnt), 32'(1));
    check("wr_ram_we",   32'(ram_we),    32'(1));
    check("wr_ram_addr", 32'(ram_addr),  32'(5));
    check("wr_ram_din",  32'(ram_din),   32'(8'hA5));
    check("wr_busy",     32'(busy),      32'(1));
    step();
    check("wr_done_busy", 32'(busy),   32'(0));
    check("wr_done_we",   32'(ram_we), 32'(0));

    // B reads address 5 back.
    q_b.push_back(mk(1'b0, 5, 0));
    step();
    check("rd_gnt_b", 32'(bus_b.gnt), 32'(1));
    step();
    check("rd_early_rvalid_b", 32'(bus_b.rvalid), 32'(0));
    step();
    check("rd_rvalid_b", 32'(bus_b.rvalid), 32'(1));
    check("rd_rdata_b",  32'(bus_b.rdata),  32'(8'hA5));
    check("rd_rvalid_a", 32'(bus_a.rvalid), 32'(0));
    step();
    check("rd_done_busy", 32'(busy), 32'(0));

    // Continuous contention from reset: A writes addr 1, B writes addr 2.
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_a.push_back(mk(1'b1, 1, int'($urandom_range(0, 255))));
      q_b.push_back(mk(1'b1, 2, int'($urandom_range(0, 255))));
    end
    step();
    reset = 1'b0;
    n_g = 0;
    for (int n = 0; n < 30 && n_g < 4; n++) begin
      step();
      if (bus_a.gnt === 1'b1) begin gord[n_g] = 0; n_g++; end
      else if (bus_b.gnt === 1'b1) begin gord[n_g] = 1; n_g++; end
    end
    check("tie_grants", 32'(n_g), 32'(4));
`ifdef ARB_ROUND_ROBIN_EN
    check("tie_order0", 32'(gord[0]), 32'(0));
    check("tie_order1", 32'(gord[1]), 32'(1));
    check("tie_order2", 32'(gord[2]), 32'(0));
    check("tie_order3", 32'(gord[3]), 32'(1));
`else
    check("tie_order0", 32'(gord[0]), 32'(0));
    check("tie_order1", 32'(gord[1]), 32'(0));
    check("tie_order2", 32'(gord[2]), 32'(0));
    check("tie_order3", 32'(gord[3]), 32'(0));
`endif
    drain(100, "tie_drain");

    // Boundary addresses written then read back by A.
    q_a.push_back(mk(1'b1, 31, 8'h3C));
    q_a.push_back(mk(1'b1, 0, 8'hC3));
    q_a.push_back(mk(1'b0, 31, 0));
    q_a.push_back(mk(1'b0, 0, 0));
    n_rv = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (bus_a.rvalid === 1'b1 && n_rv < 2) begin rv[n_rv] = bus_a.rdata; n_rv++; end
    end
    check("bnd_reads", 32'(n_rv), 32'(2));
    check("bnd_rd31",  32'(rv[0]), 32'(8'h3C));
    check("bnd_rd0",   32'(rv[1]), 32'(8'hC3));

    // Reset while a B read sits in RDWAIT.
    q_b.push_back(mk(1'b0, 5, 0));
    wait_gnt(1'b1, 10, "rst_rd_gnt_b");
    step();
    check("rst_rd_busy", 32'(busy), 32'(1));
    reset = 1'b1;
    step();
    check("rst_rd_busy0",   32'(busy),         32'(0));
    check("rst_rd_rvalid",  32'(bus_b.rvalid), 32'(0));
    check("rst_rd_rdata_b", 32'(bus_b.rdata),  32'(0));
    check("rst_rd_addr",    32'(ram_addr),     32'(0));
    check("rst_rd_we",      32'(ram_we),       32'(0));
    reset = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      step();
      if (bus_b.rvalid === 1'b1) seen = 1'b1;
    end
    check("rst_rd_no_rvalid", 32'(seen), 32'(0));

    // Back-to-back writes from A.
    q_a.push_back(mk(1'b1, 7, 8'h5A));
    q_a.push_back(mk(1'b1, 8, 8'h69));
    g1 = -1; g2 = -1; n_we = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (ram_we === 1'b1) n_we++;
      if (bus_a.gnt === 1'b1) begin
        if (g1 < 0) g1 = cyc;
        else if (g2 < 0) g2 = cyc;
      end
    end
    check("b2b_gap",      32'(g2 - g1), 32'(2));
    check("b2b_we_count", 32'(n_we),    32'(2));

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if (q_a.size() < 2 && $urandom_range(0, 2) == 0) q_a.push_back(rand_cmd());
      if (q_b.size() < 2 && $urandom_range(0, 2) == 0) q_b.push_back(rand_cmd());
      reset = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 1'b0;
    drain(300, "final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
